frame_assembler: RTL and testbench
==================================

# frame_assembler

Streaming-to-frame writer that feeds the gesture classifier. It accepts RGB/HSV pixels one per handshake in raster order and writes them into a packed HEIGHT x LENGTH x 3 x 8 image register. It then presents the completed frame with a one-cycle `start` pulse and holds it stable until the consumer acknowledges. It is the producer end of the classifier's `image`/`startin` interface.

## Interface
- `HEIGHT`, default from `global_params.vh` (16): image rows.
- `LENGTH`, default from `global_params.vh` (16): image columns.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_ready`  out  1  block can accept a pixel this cycle.
- `pix_sof`  in  1  qualifies the current pixel as first of frame, i.e. pixel (0,0).
- `pix_data`  in  24  pixel; [23:16] to channel 2, [15:8] to channel 1, [7:0] to channel 0.
- `image`  out  HEIGHT*LENGTH*24, packed `[HEIGHT-1:0][LENGTH-1:0][2:0][7:0]`  assembled frame.
- `frame_valid`  out  1  `image` holds a complete frame.
- `start`  out  1  one-cycle pulse on the first cycle of `frame_valid`.
- `frame_ack`  in  1  consumer done with the frame.
- `sof_err`  out  1  one-cycle pulse when `pix_sof` arrives mid-frame.
- `frame_cnt`  out  8  completed frames, wraps 255 to 0.

## Operation
- A transfer occurs on a rising edge when `pix_valid && pix_ready`.
- States are IDLE, FILL and HOLD. Reset enters IDLE.
- IDLE:
  - `pix_ready` = 1.
  - A transfer without `pix_sof` is consumed and dropped.
  - A transfer with `pix_sof` writes `image[0][0]`, sets col=1, row=0 and goes to FILL. If LENGTH = HEIGHT = 1 it goes straight to HOLD.
- FILL:
  - `pix_ready` = 1.
  - Each transfer writes `image[row][col]`, then increments col.
  - col wraps from LENGTH-1 to 0, and row increments on that wrap.
  - The transfer at (HEIGHT-1, LENGTH-1) goes to HOLD and increments `frame_cnt`.
- FILL resync:
  - A transfer with `pix_sof` in FILL writes `image[0][0]`, sets col=1, row=0 and stays in FILL.
  - `sof_err` pulses on the next cycle.
  - `frame_cnt` is unchanged.
- HOLD:
  - `pix_ready` = 0.
  - `frame_valid` = 1 and `image` is frozen.
  - `frame_ack` high goes to IDLE. This includes ack in the same cycle as `start`.
- `frame_ack` outside HOLD is ignored.
- Pixels not overwritten keep their old values. `image` is only cleared by reset.
- Reset mid-frame discards the partial frame. Reset in HOLD drops `frame_valid` immediately.

## Timing
- Reset values:
  - `image` = 0, `frame_valid` = 0, `start` = 0, `sof_err` = 0, `frame_cnt` = 0.
  - `pix_ready` = 0 while `rst` is high, 1 in the first cycle after release.
- `pix_ready` is decoded from registered state only. There is no combinational path from `pix_valid`.
- Last-pixel latency: last transfer on edge N gives `frame_valid` = 1, `start` = 1 and updated `frame_cnt` after edge N. `start` = 0 after edge N+1.
- Ack latency: `frame_ack` sampled at edge M gives `frame_valid` = 0 and `pix_ready` = 1 after edge M. A new `pix_sof` can transfer at edge M+1.
- Throughput is one pixel per cycle in FILL. Minimum frame period is HEIGHT*LENGTH + 1 cycles with immediate ack.
- Counter widths:
  - row is max(1, $clog2(HEIGHT)) bits; col is max(1, $clog2(LENGTH)) bits.
  - The compare is against HEIGHT-1 / LENGTH-1, not a power-of-two overflow.

## Structure
- `frame_pkg` holds:
  - `pixel_t` (`logic [2:0][7:0]`);
  - the `state_t` enum {IDLE, FILL, HOLD};
  - `FRAME_PIXELS` = HEIGHT*LENGTH.
- HEIGHT/LENGTH stay in `global_params.vh`.
- Sub-module `pixel_addr_counter`:
  - Function: row/col counter with clear-to-(0,1) on sof, increment enable, and a combinational `last` flag.
  - Instantiation: `frame_assembler` instantiates it once.
- Write decode is one enable per (row, col) from the counter outputs.

## Test plan
- Nominal frame:
  - Stimulus: sof plus 256 pixels with value k at index k, `frame_ack` held low.
  - Required: `image[r][c]` = r*16+c on all channels, `start` high exactly 1 cycle, `frame_cnt` = 1, `pix_ready` = 0 until ack.
- Pre-sof garbage: 5 pixels without sof in IDLE, then a normal frame → garbage dropped, frame is correct, `frame_cnt` = 1.
- Mid-frame resync: sof at pixel 40 of a frame, then 256 pixels → `sof_err` pulses once, image matches the second sequence, `frame_cnt` = 1.
- Ack/backpressure:
  - Stimulus: ack asserted in the same cycle as `start`, next frame driven back-to-back with `pix_valid` held high.
  - Required: second sof accepted one cycle after ack, no pixel lost or duplicated.
- Reset mid-frame:
  - Stimulus: `rst` pulsed asynchronously at pixel 100, then a full frame.
  - Required: outputs return to reset values immediately, image cleared, subsequent frame correct.
- Counter wrap: 256 frames with immediate ack → `frame_cnt` goes 255 → 0, `start` count = 256.

Source files
------------

// File: rtl/frame_assembler_pkg.sv
// Shared types and default frame geometry for the frame assembler and its counter.
package frame_pkg;

  localparam int DEF_HEIGHT   = 16;
  localparam int DEF_LENGTH   = 16;
  localparam int FRAME_PIXELS = DEF_HEIGHT * DEF_LENGTH;

  typedef logic [2:0][7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/frame_assembler_pixel_addr_counter.sv
// Raster row/col position of the next pixel to write; sof clears to the slot after (0,0).
module pixel_addr_counter #(
  parameter int HEIGHT = 16,
  parameter int LENGTH = 16,
  parameter int RW     = 4,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(LENGTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      // Single-column frames advance to the next row instead of column 1.
      if (LENGTH > 1) begin
        row <= '0;
        col <= CW'(1);
      end else begin
        row <= (HEIGHT > 1) ? RW'(1) : '0;
        col <= '0;
      end
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/frame_assembler.sv
// Collects a raster pixel stream into a packed frame register and hands it to the
// consumer with a start pulse, holding it frozen until acknowledged.
module frame_assembler
  import frame_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic                                   pix_sof,
  input  logic [23:0]                            pix_data,
  output logic [HEIGHT-1:0][LENGTH-1:0][2:0][7:0] image,
  output logic                                   frame_valid,
  output logic                                   start,
  input  logic                                   frame_ack,
  output logic                                   sof_err,
  output logic [7:0]                             frame_cnt
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam bit SINGLE_PIXEL = (HEIGHT * LENGTH == 1);

  state_t        state_reg;
  logic          ready_reg;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;
  logic          xfer;
  logic          sof_xfer;
  logic          fill_xfer;

  assign pix_ready = ready_reg;
  assign xfer      = pix_valid && ready_reg;
  assign sof_xfer  = xfer && pix_sof;
  assign fill_xfer = xfer && !pix_sof && (state_reg == FILL);

  pixel_addr_counter #(
    .HEIGHT(HEIGHT),
    .LENGTH(LENGTH),
    .RW    (RW),
    .CW    (CW)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clear(sof_xfer),
    .inc  (fill_xfer),
    .row  (row),
    .col  (col),
    .last (last)
  );

  genvar gi, gj;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row
      for (gj = 0; gj < LENGTH; gj++) begin : g_col
        logic   wr_en;
        pixel_t pix_q;

        assign wr_en = (sof_xfer && (gi == 0) && (gj == 0)) ||
                       (fill_xfer && (row == RW'(gi)) && (col == CW'(gj)));

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pix_q <= '0;
          end else if (wr_en) begin
            pix_q <= pix_data;
          end
        end

        assign image[gi][gj] = pix_q;
      end
    end
  endgenerate

  // ready_reg is loaded with the acceptance decision for the coming state so
  // the handshake never depends combinationally on pix_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b0;
      frame_valid <= 1'b0;
      start       <= 1'b0;
      sof_err     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      start     <= 1'b0;
      sof_err   <= 1'b0;
      ready_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (sof_xfer) begin
            if (SINGLE_PIXEL) begin
              state_reg   <= HOLD;
              ready_reg   <= 1'b0;
              frame_valid <= 1'b1;
              start       <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        FILL: begin
          if (sof_xfer) begin
            sof_err <= 1'b1;
          end else if (fill_xfer && last) begin
            state_reg   <= HOLD;
            ready_reg   <= 1'b0;
            frame_valid <= 1'b1;
            start       <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (frame_ack) begin
            state_reg   <= IDLE;
            frame_valid <= 1'b0;
          end else begin
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Randomised scoreboard bench for frame_assembler: a raster-index model predicts each
// frame, and a monitor compares whenever start or sof_err is presented.
module tb_frame_assembler;
  import frame_pkg::*;

  localparam int H = 16;
  localparam int L = 16;
  localparam int TIMEOUT = 2000;

  typedef logic [H-1:0][L-1:0][2:0][7:0] img_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        pix_sof = 1'b0;
  logic [23:0] pix_data = '0;
  img_t        image;
  logic        frame_valid;
  logic        start;
  logic        frame_ack = 1'b0;
  logic        sof_err;
  logic [7:0]  frame_cnt;

  frame_assembler #(.HEIGHT(H), .LENGTH(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .image      (image),
    .frame_valid(frame_valid),
    .start      (start),
    .frame_ack  (frame_ack),
    .sof_err    (sof_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;

  img_t model_img;
  int   idx;
  bit   in_frame;
  bit   hold;
  int   model_cnt;
  int   sof_pending;
  img_t exp_img_q[$];
  int   exp_cnt_q[$];
  bit   in_reset;
  bit   auto_ack;
  bit   b2b;
  bit   gap_armed;
  int   ack_cyc;
  int   start_count;
  bit   prev_start;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int first_diff(input img_t a, input img_t b);
    for (int k = 0; k < H * L; k++)
      if (a[k / L][k % L] !== b[k / L][k % L]) return k;
    return -1;
  endfunction

  task automatic check_img(input string name, input img_t act, input img_t req);
    int d;
    d = first_diff(act, req);
    if (d < 0) check(1'b1, name, 0, 0);
    else check(1'b0, {name, "_pixel_idx_", $sformatf("%0d", d)},
               longint'(act[d / L][d % L]), longint'(req[d / L][d % L]));
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        check(pix_ready === !hold, "pix_ready", pix_ready, !hold);
        if (prev_start) check(start === 1'b0, "start_one_cycle", start, 0);
        if (start) begin
          start_count++;
          if (exp_img_q.size() == 0) begin
            check(1'b0, "unexpected_start", 1, 0);
          end else begin
            img_t ei;
            int   ec;
            ei = exp_img_q.pop_front();
            ec = exp_cnt_q.pop_front();
            check(frame_valid === 1'b1, "frame_valid_at_start", frame_valid, 1);
            check(frame_cnt === 8'(ec), "frame_cnt", frame_cnt, ec);
            check_img("frame_image", image, ei);
          end
        end
        if (sof_err) begin
          check(sof_pending > 0, "sof_err_expected", 1, sof_pending);
          if (sof_pending > 0) sof_pending--;
        end
        prev_start = start;
      end
    end
  endtask

  task automatic model_xfer(input bit sof, input logic [23:0] d);
    if (sof) begin
      if (in_frame) sof_pending++;
      if (gap_armed) begin
        check(cyc - ack_cyc == 1, "sof_after_ack_gap", cyc - ack_cyc, 1);
        gap_armed = 0;
      end
      model_img[0][0] = d;
      idx = 1;
      in_frame = 1;
    end else if (in_frame) begin
      model_img[idx / L][idx % L] = d;
      idx++;
    end
    if (in_frame && idx == H * L) begin
      in_frame = 0;
      hold = 1;
      model_cnt = (model_cnt + 1) % 256;
      exp_img_q.push_back(model_img);
      exp_cnt_q.push_back(model_cnt);
      if (auto_ack) frame_ack = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_ack && hold) begin
      frame_ack = 1'b0;
      hold = 0;
      ack_cyc = cyc;
      gap_armed = b2b;
    end
  endtask

  task automatic abort(input string name);
    check(1'b0, name, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench aborted");
  endtask

  task automatic send(input bit sof, input logic [23:0] d);
    int waited;
    waited = 0;
    pix_valid = 1'b1;
    pix_sof = sof;
    pix_data = d;
    while (!pix_ready) begin
      step();
      waited++;
      if (waited > TIMEOUT) abort("ready_timeout");
    end
    @(posedge clk);
    #1;
    model_xfer(sof, d);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack_frame();
    pix_valid = 1'b0;
    frame_ack = 1'b1;
    step();
    check(frame_valid === 1'b0, "frame_valid_after_ack", frame_valid, 0);
    check(pix_ready === 1'b1, "pix_ready_after_ack", pix_ready, 1);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    in_reset = 1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    frame_ack = 1'b0;
    #1;
    check(frame_valid === 1'b0, "rst_frame_valid", frame_valid, 0);
    check(start === 1'b0, "rst_start", start, 0);
    check(sof_err === 1'b0, "rst_sof_err", sof_err, 0);
    check(frame_cnt === 8'd0, "rst_frame_cnt", frame_cnt, 0);
    check(pix_ready === 1'b0, "rst_pix_ready", pix_ready, 0);
    check_img("rst_image", image, '0);
    model_img = '0;
    idx = 0;
    in_frame = 0;
    hold = 0;
    model_cnt = 0;
    gap_armed = 0;
    prev_start = 0;
    check(exp_img_q.size() == 0, "frames_outstanding_at_reset", exp_img_q.size(), 0);
    check(sof_pending == 0, "sof_err_outstanding_at_reset", sof_pending, 0);
    exp_img_q.delete();
    exp_cnt_q.delete();
    sof_pending = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check(pix_ready === 1'b1, "pix_ready_after_release", pix_ready, 1);
    in_reset = 0;
  endtask

  task automatic rand_frame();
    send(1'b1, 24'($urandom));
    for (int k = 1; k < H * L; k++) send(1'b0, 24'($urandom));
  endtask

  initial begin
    int s0;
    model_img = '0;
    idx = 0;
    in_frame = 0;
    hold = 0;
    model_cnt = 0;
    sof_pending = 0;
    auto_ack = 0;
    b2b = 0;
    gap_armed = 0;
    ack_cyc = 0;
    start_count = 0;
    prev_start = 0;
    in_reset = 1;
    fork
      monitor_loop();
    join_none
    @(posedge clk);
    #1;
    apply_reset();

    // Nominal frame: value k at raster index k on every channel, ack held off.
    for (int k = 0; k < FRAME_PIXELS; k++) send(k == 0, {8'(k), 8'(k), 8'(k)});
    idle(5);
    check(frame_valid === 1'b1, "hold_frame_valid", frame_valid, 1);
    check(frame_cnt === 8'd1, "nominal_frame_cnt", frame_cnt, 1);
    check(image[3][7] === {8'd55, 8'd55, 8'd55}, "nominal_pixel_3_7", image[3][7], 24'h373737);
    check(image[15][15] === 24'hFFFFFF, "nominal_pixel_15_15", image[15][15], 24'hFFFFFF);
    check_img("hold_image_frozen", image, model_img);
    ack_frame();

    // Garbage before sof is dropped.
    apply_reset();
    for (int k = 0; k < 5; k++) send(1'b0, 24'($urandom));
    rand_frame();
    idle(2);
    ack_frame();

    // Resync: sof arrives as the 41st pixel, restarting the frame.
    apply_reset();
    send(1'b1, 24'($urandom));
    for (int k = 1; k < 40; k++) send(1'b0, 24'($urandom));
    rand_frame();
    idle(2);
    check(frame_cnt === 8'd1, "resync_frame_cnt", frame_cnt, 1);
    check(sof_pending == 0, "resync_sof_err_seen", sof_pending, 0);
    ack_frame();

    // Ack in the start cycle with the next frame pressed back-to-back.
    apply_reset();
    auto_ack = 1;
    b2b = 1;
    rand_frame();
    rand_frame();
    rand_frame();
    idle(3);
    check(frame_cnt === 8'd3, "b2b_frame_cnt", frame_cnt, 3);
    auto_ack = 0;
    b2b = 0;

    // Asynchronous reset partway through a frame.
    apply_reset();
    send(1'b1, 24'($urandom));
    for (int k = 1; k < 100; k++) send(1'b0, 24'($urandom));
    apply_reset();
    rand_frame();
    idle(2);
    ack_frame();

    // Frame counter wrap with immediate ack.
    apply_reset();
    auto_ack = 1;
    b2b = 1;
    s0 = start_count;
    for (int f = 0; f < 256; f++) rand_frame();
    idle(3);
    check(start_count - s0 == 256, "wrap_start_count", start_count - s0, 256);
    check(frame_cnt === 8'd0, "wrap_frame_cnt", frame_cnt, 0);
    auto_ack = 0;
    b2b = 0;

    idle(3);
    check(exp_img_q.size() == 0, "frames_outstanding", exp_img_q.size(), 0);
    check(sof_pending == 0, "sof_err_outstanding", sof_pending, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
